// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
//   Round-robin arbiter that lets four requesters share one VGA pixel-write
//   port. The winning requester's rectangle is rasterised one pixel per
//   cycle: columns form the inner loop and rows the outer loop.
//
//   Optional build macro: VGA_DRAW_ARB_CLIP_EN
//     When defined, pixels whose unwrapped coordinate lies outside
//     SCREEN_W x SCREEN_H are not written. They still take their cycle,
//     so the done timing does not change.
//
//   Ports
//     clk          in   rising-edge clock
//     reset        in   synchronous, active-high reset
//     req[3:0]     in   draw request, bit i = requester i
//     rect_x/y/w/h in   4 x 8-bit origin and size, requester i at [8i+7:8i]
//     rect_colour  in   4 x 9-bit colour, requester i at [9i+8:9i]
//     grant[3:0]   out  one-hot owner, from the first DRAW cycle to DONE
//     done[3:0]    out  one-cycle pulse when the owner's rectangle finishes
//     x_out/y_out  out  pixel coordinate (registered)
//     colour_out   out  pixel colour (registered)
//     plot         out  pixel write enable (registered)
module vga_draw_arbiter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] rect_x,
  input  logic [31:0] rect_y,
  input  logic [31:0] rect_w,
  input  logic [31:0] rect_h,
  input  logic [35:0] rect_colour,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [7:0]  x_out,
  output logic [7:0]  y_out,
  output logic [8:0]  colour_out,
  output logic        plot
);

`ifdef VGA_DRAW_ARB_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r, next_state_s;
  logic [1:0]  ptr_r, win_r, winner_s;
  logic [7:0]  x0_r, y0_r, w_r, h_r, col_r, row_r;
  logic [8:0]  colour_r;
  logic        finished_r;
  logic [3:0]  grant_r, done_r;
  logic [7:0]  x_out_r, y_out_r;
  logic [8:0]  colour_out_r;
  logic        plot_r;

  logic        zero_area_s, fire_s, last_pix_s, in_bounds_s, plot_next_s;
  logic [8:0]  x_sum_s, y_sum_s;

  // First requester found scanning upward from the pointer, wrapping 3 -> 0.
  // Scanning the offsets from far to near lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. DRAW needs one extra cycle after the last pixel is
  // issued so that the registered pixel is visible before DONE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (req != 4'd0) next_state_s = DRAW; else next_state_s = IDLE;
      DRAW:    if (finished_r || zero_area_s) next_state_s = DONE; else next_state_s = DRAW;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Combinational decode: winner selection, pixel issue and clip test.
  always_comb begin
    winner_s    = rr_pick(req, ptr_r);
    zero_area_s = (w_r == 8'd0) || (h_r == 8'd0);
    fire_s      = (state_r == DRAW) && !finished_r && !zero_area_s;
    last_pix_s  = (col_r == (w_r - 8'd1)) && (row_r == (h_r - 8'd1));
    x_sum_s     = {1'b0, x0_r} + {1'b0, col_r};
    y_sum_s     = {1'b0, y0_r} + {1'b0, row_r};
    in_bounds_s = (x_sum_s < 9'(SCREEN_W)) && (y_sum_s < 9'(SCREEN_H));
    plot_next_s = fire_s && (!CLIP_EN || in_bounds_s);
  end

  // Rectangle latch, raster counters and priority pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r      <= 2'd0;
      win_r      <= 2'd0;
      x0_r       <= 8'd0;
      y0_r       <= 8'd0;
      w_r        <= 8'd0;
      h_r        <= 8'd0;
      colour_r   <= 9'd0;
      col_r      <= 8'd0;
      row_r      <= 8'd0;
      finished_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req != 4'd0) begin
            win_r      <= winner_s;
            x0_r       <= rect_x[8*winner_s +: 8];
            y0_r       <= rect_y[8*winner_s +: 8];
            w_r        <= rect_w[8*winner_s +: 8];
            h_r        <= rect_h[8*winner_s +: 8];
            colour_r   <= rect_colour[9*winner_s +: 9];
            col_r      <= 8'd0;
            row_r      <= 8'd0;
            finished_r <= 1'b0;
          end
        end
        DRAW: begin
          if (fire_s) begin
            if (col_r == (w_r - 8'd1)) begin
              col_r <= 8'd0;
              row_r <= row_r + 8'd1;
            end else begin
              col_r <= col_r + 8'd1;
            end
            if (last_pix_s) finished_r <= 1'b1;
          end
        end
        DONE:    ptr_r <= win_r + 2'd1;
        default: ptr_r <= ptr_r;
      endcase
    end
  end

  // Registered outputs. Pixel fields update only on a written pixel, so they
  // hold their last value whenever plot is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r      <= 4'd0;
      done_r       <= 4'd0;
      plot_r       <= 1'b0;
      x_out_r      <= 8'd0;
      y_out_r      <= 8'd0;
      colour_out_r <= 9'd0;
    end else begin
      if (state_r == IDLE && req != 4'd0) begin
        grant_r <= 4'd1 << winner_s;
      end else if (state_r == DONE) begin
        grant_r <= 4'd0;
      end else begin
        grant_r <= grant_r;
      end
      done_r <= (state_r == DRAW && next_state_s == DONE) ? grant_r : 4'd0;
      plot_r <= plot_next_s;
      if (plot_next_s) begin
        x_out_r      <= x_sum_s[7:0];
        y_out_r      <= y_sum_s[7:0];
        colour_out_r <= colour_r;
      end
    end
  end

  assign grant      = grant_r;
  assign done       = done_r;
  assign plot       = plot_r;
  assign x_out      = x_out_r;
  assign y_out      = y_out_r;
  assign colour_out = colour_out_r;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
module tb_vga_draw_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] rect_x, rect_y, rect_w, rect_h;
  logic [35:0] rect_colour;
  logic [3:0]  grant, done;
  logic [7:0]  x_out, y_out;
  logic [8:0]  colour_out;
  logic        plot;

  int tests = 0;
  int fails = 0;

  vga_draw_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_colour(rect_colour),
    .grant(grant), .done(done), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rect(input int i, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] w, input logic [7:0] h, input logic [8:0] c);
    rect_x[8*i +: 8]      = x;
    rect_y[8*i +: 8]      = y;
    rect_w[8*i +: 8]      = w;
    rect_h[8*i +: 8]      = h;
    rect_colour[9*i +: 9] = c;
  endtask

  task automatic do_reset();
    req   = 4'd0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a grant, compare it, then wait for it to drop.
  task automatic expect_grant(input string tag, input logic [3:0] exp);
    int n;
    n = 0;
    while (grant == 4'd0 && n < 20) begin step(); n++; end
    chk(tag, {28'd0, grant}, {28'd0, exp});
    n = 0;
    while (grant != 4'd0 && n < 20) begin step(); n++; end
    chk({tag, "_release"}, {28'd0, grant}, 32'd0);
  endtask

  initial begin
    req = 4'd0; rect_x = 32'd0; rect_y = 32'd0; rect_w = 32'd0; rect_h = 32'd0;
    rect_colour = 36'd0;
    reset = 1'b1;
    step(); step();
    // Reset state
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_plot", {31'd0, plot}, 32'd0);
    chk("rst_x", {24'd0, x_out}, 32'd0);
    chk("rst_y", {24'd0, y_out}, 32'd0);
    chk("rst_colour", {23'd0, colour_out}, 32'd0);
    reset = 1'b0;
    step();

    // Single 2x2 draw; this cycle is T
    set_rect(0, 8'd10, 8'd20, 8'd2, 8'd2, 9'h1C0);
    req = 4'b0001;
    step(); req = 4'b0000;                        // T+1
    chk("s_grant_t1", {28'd0, grant}, 32'h1);
    chk("s_plot_t1", {31'd0, plot}, 32'd0);
    step();                                       // T+2
    chk("s_plot_t2", {31'd0, plot}, 32'd1);
    chk("s_xy_t2", {16'd0, x_out, y_out}, {16'd0, 8'd10, 8'd20});
    chk("s_col_t2", {23'd0, colour_out}, 32'h1C0);
    step();                                       // T+3
    chk("s_xy_t3", {15'd0, plot, x_out, y_out}, {15'd0, 1'b1, 8'd11, 8'd20});
    step();                                       // T+4
    chk("s_xy_t4", {15'd0, plot, x_out, y_out}, {15'd0, 1'b1, 8'd10, 8'd21});
    step();                                       // T+5
    chk("s_xy_t5", {15'd0, plot, x_out, y_out}, {15'd0, 1'b1, 8'd11, 8'd21});
    chk("s_done_t5", {28'd0, done}, 32'd0);
    step();                                       // T+6
    chk("s_plot_t6", {31'd0, plot}, 32'd0);
    chk("s_done_t6", {28'd0, done}, 32'h1);
    chk("s_grant_t6", {28'd0, grant}, 32'h1);
    chk("s_hold_t6", {16'd0, x_out, y_out}, {16'd0, 8'd11, 8'd21});
    step();                                       // T+7
    chk("s_done_t7", {28'd0, done}, 32'd0);
    chk("s_grant_t7", {28'd0, grant}, 32'd0);

    // Round robin with all four requesting 1x1 rectangles
    do_reset();
    for (int i = 0; i < 4; i++) set_rect(i, 8'(i), 8'd1, 8'd1, 8'd1, 9'(i + 1));
    req = 4'b1111;
    expect_grant("rr0", 4'b0001);
    expect_grant("rr1", 4'b0010);
    expect_grant("rr2", 4'b0100);
    expect_grant("rr3", 4'b1000);
    expect_grant("rr4", 4'b0001);

    // Fairness between requesters 0 and 2
    do_reset();
    req = 4'b0101;
    expect_grant("fair0", 4'b0001);
    expect_grant("fair1", 4'b0100);
    expect_grant("fair2", 4'b0001);
    expect_grant("fair3", 4'b0100);

    // Zero-area rectangle
    do_reset();
    step();
    set_rect(0, 8'd5, 8'd5, 8'd0, 8'd5, 9'h0FF);
    req = 4'b0001;                                // T
    step(); req = 4'b0000;                        // T+1
    chk("z_grant_t1", {28'd0, grant}, 32'h1);
    chk("z_plot_t1", {31'd0, plot}, 32'd0);
    step();                                       // T+2
    chk("z_done_t2", {28'd0, done}, 32'h1);
    chk("z_plot_t2", {31'd0, plot}, 32'd0);
    step();                                       // T+3
    chk("z_done_t3", {28'd0, done}, 32'd0);
    chk("z_plot_t3", {31'd0, plot}, 32'd0);

    // Right-edge rectangle (clip or wrap-free overrun)
    do_reset();
    set_rect(3, 8'd158, 8'd5, 8'd4, 8'd1, 9'h03F);
    req = 4'b1000;                                // T
    step(); req = 4'b0000;                        // T+1
    chk("c_grant_t1", {28'd0, grant}, 32'h8);
    step();                                       // T+2
    chk("c_p0", {23'd0, plot, x_out}, {23'd0, 1'b1, 8'd158});
    step();                                       // T+3
    chk("c_p1", {23'd0, plot, x_out}, {23'd0, 1'b1, 8'd159});
    step();                                       // T+4
`ifdef VGA_DRAW_ARB_CLIP_EN
    chk("c_p2", {23'd0, plot, x_out}, {23'd0, 1'b0, 8'd159});
    step();
    chk("c_p3", {23'd0, plot, x_out}, {23'd0, 1'b0, 8'd159});
`else
    chk("c_p2", {23'd0, plot, x_out}, {23'd0, 1'b1, 8'd160});
    step();
    chk("c_p3", {23'd0, plot, x_out}, {23'd0, 1'b1, 8'd161});
`endif
    step();                                       // T+6
    chk("c_done_t6", {28'd0, done}, 32'h8);

    // Reset in the middle of a 4x4 draw
    do_reset();
    set_rect(2, 8'd0, 8'd0, 8'd4, 8'd4, 9'h155);
    req = 4'b0100;                                // T
    step(); req = 4'b0000;                        // T+1
    step(); step(); step();                       // T+4: third pixel
    chk("r_third", {23'd0, plot, x_out}, {23'd0, 1'b1, 8'd2});
    reset = 1'b1;
    step();                                       // T+5
    chk("r_grant", {28'd0, grant}, 32'd0);
    chk("r_plot", {31'd0, plot}, 32'd0);
    chk("r_done", {28'd0, done}, 32'd0);
    reset = 1'b0;
    set_rect(1, 8'd7, 8'd9, 8'd1, 8'd1, 9'h0AA);
    req = 4'b0010;                                // new T
    step(); req = 4'b0000;
    chk("r_regrant", {28'd0, grant}, 32'h2);
    step();
    chk("r_pix", {15'd0, plot, x_out, y_out}, {15'd0, 1'b1, 8'd7, 8'd9});
    chk("r_pixcol", {23'd0, colour_out}, 32'h0AA);
    step();
    chk("r_done2", {28'd0, done}, 32'h2);
    step();
    chk("r_done2_end", {28'd0, done}, 32'd0);
    // No stray done on the abandoned requester at any point afterwards
    chk("r_grant_end", {28'd0, grant}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_draw_arbiter.md
VGA_DRAW_ARBITER -- requirements
Module: vga_draw_arbiter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160: visible width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120: visible height in pixels.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req, input, 4: per-requester draw request, bit i = requester i.
REQ-006 SHALL have port rect_x, input, 32: four 8-bit rectangle origin X values; requester i uses [8i+7:8i].
REQ-007 SHALL have port rect_y, input, 32: four 8-bit origin Y values, same packing.
REQ-008 SHALL have port rect_w, input, 32: four 8-bit widths in pixels, same packing.
REQ-009 SHALL have port rect_h, input, 32: four 8-bit heights in pixels, same packing.
REQ-010 SHALL have port rect_colour, input, 36: four 9-bit colours; requester i uses [9i+8:9i].
REQ-011 SHALL have port grant, output, 4: one-hot; the requester currently being drawn.
REQ-012 SHALL have port done, output, 4: one-cycle pulse to the requester whose rectangle finished.
REQ-013 SHALL have port x_out, output, 8: pixel X to the VGA adapter.
REQ-014 SHALL have port y_out, output, 8: pixel Y to the VGA adapter.
REQ-015 SHALL have port colour_out, output, 9: pixel colour to the VGA adapter.
REQ-016 SHALL have port plot, output, 1: write enable to the VGA adapter.

Function
REQ-017 SHALL implement the states IDLE, DRAW and DONE.
REQ-018 IDLE with req != 0: SHALL pick a winner round-robin, starting the search at the priority pointer and ascending with wrap from 3 to 0.
REQ-019 On that IDLE edge, SHALL latch the winner's x, y, w, h and colour, clear the column and row counters, and go to DRAW.
REQ-020 SHALL hold grant one-hot for the winner from the first DRAW cycle through the DONE cycle inclusive; grant SHALL be 0 otherwise.
REQ-021 DRAW: SHALL issue one pixel per cycle, with the column index as the inner loop and the row index as the outer loop.
REQ-022 Pixel coordinates SHALL be x = x0+col and y = y0+row, each truncated to 8 bits (modulo-256 wrap).
REQ-023 Pixel outputs SHALL be registered; if req is sampled in IDLE at cycle T, the first plot SHALL occur at T+2.
REQ-024 plot SHALL be high for exactly w*h consecutive cycles; colour_out SHALL equal the latched colour while plot is high.
REQ-025 After the last pixel, the FSM SHALL enter DONE; done[winner] SHALL pulse in the cycle immediately after the last plot cycle.
REQ-026 w=0 or h=0: SHALL emit no plot and pulse done at T+2.
REQ-027 In DONE, SHALL set the priority pointer to winner+1 (mod 4) and return to IDLE.
REQ-028 The earliest next arbitration SHALL be in the cycle after done.
REQ-029 req and rect inputs SHALL be ignored outside IDLE; deasserting req mid-draw SHALL NOT abort the draw.
REQ-030 When plot is low, x_out, y_out and colour_out SHALL hold their last values.

Reset
REQ-031 On reset: SHALL set state=IDLE, pointer=0, grant=0, done=0, plot=0, x_out=0, y_out=0, colour_out=0.
REQ-032 Reset during DRAW SHALL abandon the rectangle with no done pulse; the first edge after reset is released SHALL be able to arbitrate.

Configuration
REQ-033 With macro VGA_DRAW_ARB_CLIP_EN defined: plot SHALL be forced low for any pixel with unwrapped x0+col >= SCREEN_W or y0+row >= SCREEN_H.
REQ-034 With VGA_DRAW_ARB_CLIP_EN defined, clipped pixels SHALL still consume their cycle, so the done timing is unchanged.
REQ-035 Without VGA_DRAW_ARB_CLIP_EN: no clipping; coordinates wrap per REQ-022 and plot is high for every pixel.

Verification
REQ-036 Single draw: req=0001, (10,20), w=2, h=2, colour 9'h1C0 -> plots (10,20),(11,20),(10,21),(11,21) from T+2; done=0001 at T+6; grant=0001 T+1..T+6.
REQ-037 Simultaneous requests: req=1111 held, all 1x1, after reset -> grant order 0001,0010,0100,1000, then 0001.
REQ-038 Fairness: req 0 and 2 held continuously -> grants alternate 0001,0100,0001,...
REQ-039 Zero area: w=0, h=5 -> no plot; done pulses at T+2.
REQ-040 Clip: x0=158, w=4, h=1 -> with VGA_DRAW_ARB_CLIP_EN, plot only at x=158,159, done at T+6; without it, plot at 158,159,160,161.
REQ-041 Reset mid-draw: reset at the 3rd pixel of a 4x4 rectangle -> plot, grant, done all 0 next cycle; a new req=0010 is granted normally.
